// File: rtl/f_cmp_pkg.sv
// Shared types, constants and helpers for the f_comparator on-chip checker.
package f_cmp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DRIVE   = 3'd1,
        ST_COMPARE = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    localparam int unsigned SIGN_BIT = 31;
    localparam int unsigned EXP_MSB  = 30;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned MAN_MSB  = 22;
    localparam logic [7:0]  EXP_ALL1 = 8'hFF;

    localparam int unsigned          BIT_W     = 5;
    localparam logic [BIT_W-1:0]     BIT_START = BIT_W'(EXP_MSB);

    // Exponent all ones with a non-zero mantissa.
    function automatic logic is_nan(input logic [31:0] f);
        return (f[EXP_MSB:EXP_LSB] == EXP_ALL1) && (f[MAN_MSB:0] != '0);
    endfunction

    // Magnitude zero, either sign.
    function automatic logic is_zero(input logic [31:0] f);
        return (f[EXP_MSB:0] == '0);
    endfunction

    // One Galois step, shifting right, taps from LFSR_MASK.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
    endfunction

endpackage

// File: rtl/f_cmp_lfsr32.sv
// 32-bit Galois LFSR operand source; load takes priority over step.
module f_cmp_lfsr32
    import f_cmp_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    output logic [31:0] q
);

    // Seed on reset or load, otherwise advance one step when asked.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            q <= SEED;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/f_comparator_checker.sv
// BIST driver/checker for f_comparator: LFSR operands, bit-serial reference, mismatch counting.
module f_comparator_checker
    import f_cmp_pkg::*;
#(
    parameter int unsigned N_VECTORS = 4096,
    parameter logic [31:0] SEED0     = 32'h1234_5678,
    parameter logic [31:0] SEED1     = 32'h8765_4321,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [31:0]      dut_in0,
    output logic [31:0]      dut_in1,
    input  logic             dut_res,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_idx,
    output logic             exp_res,
    output logic [CNT_W-1:0] err_cnt,
    output logic             first_fail_valid,
    output logic [CNT_W-1:0] first_fail_idx
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VECTORS - 1);

    state_t           state;
    state_t           state_next;
    logic [BIT_W-1:0] bit_ptr;
    logic             gt;
    logic             lt;
    logic [31:0]      lfsr0_q;
    logic [31:0]      lfsr1_q;

    logic lfsr_load;
    logic lfsr_step;
    logic clear_run;
    logic drive_en;
    logic cmp_en;
    logic check_en;
    logic last_vec_c;
    logic exp_c;
    logic mismatch_c;
    logic run_next_c;

    assign last_vec_c = (vec_idx == LAST_IDX);
    assign mismatch_c = (dut_res != exp_c);
    assign run_next_c = (state_next == ST_DRIVE) || (state_next == ST_COMPARE) ||
                        (state_next == ST_CHECK);

    f_cmp_lfsr32 #(.SEED(SEED0)) u_lfsr0 (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .step (lfsr_step),
        .q    (lfsr0_q)
    );

    f_cmp_lfsr32 #(.SEED(SEED1)) u_lfsr1 (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .step (lfsr_step),
        .q    (lfsr1_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: fixed 33-cycle vector loop, start only honoured when idle or done.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_DRIVE;
            ST_DRIVE:   state_next = ST_COMPARE;
            ST_COMPARE: if (bit_ptr == '0) state_next = ST_CHECK;
            ST_CHECK:   state_next = last_vec_c ? ST_DONE : ST_DRIVE;
            ST_DONE:    if (start) state_next = ST_DRIVE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Per-state datapath strobes.
    always_comb begin
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        clear_run = 1'b0;
        drive_en  = 1'b0;
        cmp_en    = 1'b0;
        check_en  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                lfsr_load = start;
                clear_run = start;
            end
            ST_DRIVE:   drive_en = 1'b1;
            ST_COMPARE: cmp_en   = 1'b1;
            ST_CHECK: begin
                check_en  = 1'b1;
                lfsr_step = 1'b1;
            end
            default: ;
        endcase
    end

    // Reference result from sign/class checks plus the serial magnitude flags.
    always_comb begin
        exp_c = 1'b0;
        if (is_nan(dut_in0) || is_nan(dut_in1)) begin
            exp_c = 1'b0;
        end else if (is_zero(dut_in0) && is_zero(dut_in1)) begin
            exp_c = 1'b0;
        end else if (dut_in0[SIGN_BIT] != dut_in1[SIGN_BIT]) begin
            exp_c = ~dut_in0[SIGN_BIT];
        end else if (!dut_in0[SIGN_BIT]) begin
            exp_c = gt;
        end else begin
            exp_c = lt;
        end
    end

    // Status flags track where the FSM is heading so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= run_next_c;
            done <= (state_next == ST_DONE);
        end
    end

    // Operand registers and MSB-first magnitude compare of bits 30..0.
    always_ff @(posedge clk) begin
        if (rst) begin
            dut_in0 <= '0;
            dut_in1 <= '0;
            gt      <= 1'b0;
            lt      <= 1'b0;
            bit_ptr <= '0;
        end else if (drive_en) begin
            dut_in0 <= lfsr0_q;
            dut_in1 <= lfsr1_q;
            gt      <= 1'b0;
            lt      <= 1'b0;
            bit_ptr <= BIT_START;
        end else if (cmp_en) begin
            if (!gt && !lt && (dut_in0[bit_ptr] != dut_in1[bit_ptr])) begin
                gt <= dut_in0[bit_ptr];
                lt <= ~dut_in0[bit_ptr];
            end
            if (bit_ptr != '0) begin
                bit_ptr <= bit_ptr - BIT_W'(1);
            end
        end
    end

    // Run bookkeeping: vector index, expected result, error count, first failure.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_idx          <= '0;
            exp_res          <= 1'b0;
            err_cnt          <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else if (clear_run) begin
            vec_idx          <= '0;
            err_cnt          <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
        end else if (check_en) begin
            exp_res <= exp_c;
            if (mismatch_c) begin
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + CNT_W'(1);
                end
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_idx   <= vec_idx;
                end
            end
            if (!last_vec_c) begin
                vec_idx <= vec_idx + CNT_W'(1);
            end
        end
    end

endmodule
